// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared definitions for the GeMIPS memory-access stage.
// Holds the memory op encodings, the FSM state type and small op-class
// helpers used by mem_access and mem_lane.
package mem_access_pkg;

  localparam logic [7:0] MEM_NOP = 8'h00;
  localparam logic [7:0] MEM_LB  = 8'h01;
  localparam logic [7:0] MEM_LW  = 8'h02;
  localparam logic [7:0] MEM_SB  = 8'h03;
  localparam logic [7:0] MEM_SW  = 8'h04;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  function automatic logic is_mem_op(input logic [7:0] op);
    return (op == MEM_LB) || (op == MEM_LW) || (op == MEM_SB) || (op == MEM_SW);
  endfunction

  function automatic logic is_load_op(input logic [7:0] op);
    return (op == MEM_LB) || (op == MEM_LW);
  endfunction

  function automatic logic is_word_op(input logic [7:0] op);
    return (op == MEM_LW) || (op == MEM_SW);
  endfunction

endpackage

// File: rtl/mem_lane.sv
// mem_lane: combinational byte-lane steering for the memory-access stage.
// Issue side (i_op/i_addr_lo/i_data): byte enables, store flag and
//   replicated store data for the bus.
// Load side (i_ld_op/i_ld_lo/i_rdata): extracts and sign-extends the load
//   result; driven from the latched request since the bus answers later.
// Ports:
//   i_op, i_addr_lo, i_data   request being issued
//   o_be, o_we, o_wdata       bus byte enables / store flag / store data
//   i_ld_op, i_ld_lo, i_rdata latched load op, address low bits, bus data
//   o_ld_data                 write-back value for the load
module mem_lane
  import mem_access_pkg::*;
(
  input  logic [7:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_data,
  output logic [3:0]  o_be,
  output logic        o_we,
  output logic [31:0] o_wdata,
  input  logic [7:0]  i_ld_op,
  input  logic [1:0]  i_ld_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  logic [7:0] w_byte;

  always_comb begin
    o_be    = 4'hF;
    o_we    = (i_op == MEM_SB) || (i_op == MEM_SW);
    o_wdata = i_data;
    if ((i_op == MEM_LB) || (i_op == MEM_SB))
      o_be = 4'b0001 << i_addr_lo;
    // Byte stores put the byte on every lane; the enables pick the real one.
    if (i_op == MEM_SB)
      o_wdata = {4{i_data[7:0]}};
  end

  always_comb begin
    w_byte    = i_rdata[{i_ld_lo, 3'b000} +: 8];
    o_ld_data = i_rdata;
    if (i_ld_op == MEM_LB)
      o_ld_data = {{24{w_byte[7]}}, w_byte};
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: GeMIPS memory-access stage. Passes ALU results through to
// write-back, or runs LB/LW/SB/SW on a req/ack bus while stalling upstream.
// Optional feature macro: MEM_ALIGN_CHECK_EN -- misaligned LW/SW are
//   rejected without touching the bus and reported on bus_err_o.
// Ports:
//   clk, rst (sync, active low)
//   mem_op_i/mem_addr_i/mem_data_i  memory request from execute
//   wdata_i/waddr_i/we_i            ALU result from execute
//   wdata_o/waddr_o/we_o            registered write-back result
//   stall_req                       combinational upstream hold
//   bus_req/we/be/addr/wdata        registered bus request
//   bus_rdata/bus_ack               bus response
//   bus_err_o                       one-cycle error pulse
module mem_access
  import mem_access_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  waddr_i,
  input  logic        we_i,
  output logic [31:0] wdata_o,
  output logic [4:0]  waddr_o,
  output logic        we_o,
  output logic        stall_req,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err_o
);

  // Counter value in the last ack-less BUS cycle before giving up.
  localparam logic [7:0] TO_LAST = 8'(BUS_TIMEOUT - 1);

  state_t      r_state, w_next;
  logic [7:0]  r_cnt;
  logic [7:0]  r_op;
  logic [1:0]  r_lo;
  logic [4:0]  r_waddr;

  logic        w_misalign, w_issue, w_timeout;
  logic [3:0]  w_be;
  logic        w_we;
  logic [31:0] w_wdata, w_ld_data;

  mem_lane u_lane (
    .i_op      (mem_op_i),
    .i_addr_lo (mem_addr_i[1:0]),
    .i_data    (mem_data_i),
    .o_be      (w_be),
    .o_we      (w_we),
    .o_wdata   (w_wdata),
    .i_ld_op   (r_op),
    .i_ld_lo   (r_lo),
    .i_rdata   (bus_rdata),
    .o_ld_data (w_ld_data)
  );

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = is_word_op(mem_op_i) && (mem_addr_i[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif
  assign w_issue   = is_mem_op(mem_op_i) && !w_misalign;
  // Ack beats timeout when both land in the same cycle.
  assign w_timeout = (r_cnt == TO_LAST) && !bus_ack;

  always_comb begin
    w_next    = r_state;
    stall_req = 1'b0;
    case (r_state)
      IDLE: if (w_issue) begin
        stall_req = 1'b1;
        w_next    = BUS;
      end
      BUS: begin
        if (bus_ack || w_timeout) w_next = IDLE;
        else                      stall_req = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_op      <= MEM_NOP;
      r_lo      <= '0;
      r_waddr   <= '0;
      wdata_o   <= '0;
      waddr_o   <= '0;
      we_o      <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_err_o <= 1'b0;
    end else begin
      r_state   <= w_next;
      bus_err_o <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_op      <= mem_op_i;
            r_lo      <= mem_addr_i[1:0];
            r_waddr   <= waddr_i;
            r_cnt     <= '0;
            bus_req   <= 1'b1;
            bus_we    <= w_we;
            bus_be    <= w_be;
            bus_addr  <= {mem_addr_i[31:2], 2'b00};
            bus_wdata <= w_wdata;
            we_o      <= 1'b0;
          end else if (w_misalign) begin
            bus_err_o <= 1'b1;
            we_o      <= 1'b0;
          end else begin
            wdata_o <= wdata_i;
            waddr_o <= waddr_i;
            we_o    <= we_i;
          end
        end
        BUS: begin
          if (bus_ack || w_timeout) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_be    <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
          end
          if (bus_ack) begin
            waddr_o <= r_waddr;
            if (is_load_op(r_op)) begin
              we_o    <= 1'b1;
              wdata_o <= w_ld_data;
            end else begin
              we_o    <= 1'b0;
              wdata_o <= '0;
            end
          end else if (w_timeout) begin
            bus_err_o <= 1'b1;
            we_o      <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  localparam logic [7:0] NOP = 8'h00, LB = 8'h01, LW = 8'h02, SB = 8'h03, SW = 8'h04;

  logic        clk, rst;
  logic [7:0]  mem_op_i;
  logic [31:0] mem_addr_i, mem_data_i, wdata_i;
  logic [4:0]  waddr_i;
  logic        we_i;
  logic [31:0] wdata_o;
  logic [4:0]  waddr_o;
  logic        we_o, stall_req, bus_req, bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack, bus_err_o;

  int checks = 0;
  int failures = 0;

  // Captured during the first BUS cycle of a transaction.
  int          stalls;
  logic        cap_req, cap_we;
  logic [3:0]  cap_be;
  logic [31:0] cap_addr, cap_wdata;

  mem_access #(.BUS_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .wdata_i(wdata_i), .waddr_i(waddr_i), .we_i(we_i),
    .wdata_o(wdata_o), .waddr_o(waddr_o), .we_o(we_o), .stall_req(stall_req),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .bus_err_o(bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one memory op, let the bus answer after `waits` ack-less cycles,
  // and return at #1 after the ack edge with upstream advanced to a NOP.
  task automatic mem_txn(input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [4:0] wa,
                         input int waits, input logic [31:0] rdata);
    mem_op_i = op; mem_addr_i = addr; mem_data_i = data;
    waddr_i = wa; we_i = (op == LB || op == LW); wdata_i = 32'hCAFE_0000;
    stalls = 0;
    @(negedge clk); if (stall_req) stalls++;
    @(posedge clk); #1;
    cap_req = bus_req; cap_we = bus_we; cap_be = bus_be;
    cap_addr = bus_addr; cap_wdata = bus_wdata;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk); if (stall_req) stalls++;
      @(posedge clk); #1;
    end
    bus_ack = 1'b1; bus_rdata = rdata;
    @(negedge clk); if (stall_req) stalls++;
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    mem_op_i = NOP; we_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({wdata_o, waddr_o, we_o, bus_req, bus_we, bus_be, bus_addr, bus_wdata, bus_err_o} !== '0) begin
      failures++; $display("FAIL reset_outputs got wdata=%h waddr=%h we=%b req=%b bwe=%b be=%h addr=%h bwd=%h err=%b exp all 0",
        wdata_o, waddr_o, we_o, bus_req, bus_we, bus_be, bus_addr, bus_wdata, bus_err_o);
    end
    checks++;
    if (stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall got %b exp 0", stall_req); end
    rst = 1'b1;
  endtask

  task automatic test_alu;
    int st = 0;
    wdata_i = 32'h0000_1234; waddr_i = 5'd5; we_i = 1'b1; mem_op_i = NOP;
    bus_ack = 1'b1;  // stray ack in IDLE must be ignored
    @(negedge clk); if (stall_req) st++;
    @(posedge clk); #1;
    checks++;
    if ({wdata_o, waddr_o, we_o} !== {32'h1234, 5'd5, 1'b1}) begin
      failures++; $display("FAIL alu_pass got %h/%0d/%b exp 00001234/5/1", wdata_o, waddr_o, we_o);
    end
    @(negedge clk); if (stall_req) st++;
    checks++;
    if (st !== 0) begin failures++; $display("FAIL alu_stall got %0d exp 0", st); end
    checks++;
    if (bus_req !== 1'b0) begin failures++; $display("FAIL idle_ack_req got %b exp 0", bus_req); end
    bus_ack = 1'b0; we_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lw;
    mem_txn(LW, 32'h100, 32'h0, 5'd7, 3, 32'hDEAD_BEEF);
    checks++;
    if ({cap_req, cap_we, cap_be, cap_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
      failures++; $display("FAIL lw_bus got req=%b we=%b be=%h addr=%h exp 1/0/f/00000100", cap_req, cap_we, cap_be, cap_addr);
    end
    checks++;
    if (stalls !== 4) begin failures++; $display("FAIL lw_stall_cycles got %0d exp 4", stalls); end
    checks++;
    if ({wdata_o, waddr_o, we_o, bus_req} !== {32'hDEAD_BEEF, 5'd7, 1'b1, 1'b0}) begin
      failures++; $display("FAIL lw_result got %h/%0d/%b req=%b exp deadbeef/7/1 req=0", wdata_o, waddr_o, we_o, bus_req);
    end
  endtask

  task automatic test_lb;
    mem_txn(LB, 32'h203, 32'h0, 5'd9, 0, 32'h80FF_0000);
    checks++;
    if (cap_be !== 4'b1000) begin failures++; $display("FAIL lb_be got %b exp 1000", cap_be); end
    checks++;
    if ({wdata_o, we_o} !== {32'hFFFF_FF80, 1'b1}) begin
      failures++; $display("FAIL lb_sext got %h/%b exp ffffff80/1", wdata_o, we_o);
    end
    checks++;
    if (stalls !== 1) begin failures++; $display("FAIL lb_stall_cycles got %0d exp 1", stalls); end
    mem_txn(LB, 32'h200, 32'h0, 5'd10, 1, 32'h1234_567F);
    checks++;
    if ({cap_be, wdata_o} !== {4'b0001, 32'h0000_007F}) begin
      failures++; $display("FAIL lb_pos got be=%b data=%h exp 0001/0000007f", cap_be, wdata_o);
    end
  endtask

  task automatic test_back_to_back;
    // SB immediately followed by SW, no idle cycle between them.
    mem_txn(SB, 32'h301, 32'h0000_00A5, 5'd3, 0, 32'h0);
    checks++;
    if ({cap_we, cap_be, cap_wdata, cap_addr} !== {1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h300}) begin
      failures++; $display("FAIL sb_bus got we=%b be=%b wd=%h addr=%h exp 1/0010/a5a5a5a5/00000300", cap_we, cap_be, cap_wdata, cap_addr);
    end
    checks++;
    if ({we_o, wdata_o} !== {1'b0, 32'h0}) begin
      failures++; $display("FAIL sb_wb got we=%b data=%h exp 0/0", we_o, wdata_o);
    end
    mem_txn(SW, 32'h404, 32'h1122_3344, 5'd4, 2, 32'h0);
    checks++;
    if ({cap_req, cap_we, cap_be, cap_wdata, cap_addr} !== {1'b1, 1'b1, 4'hF, 32'h1122_3344, 32'h404}) begin
      failures++; $display("FAIL sw_bus got req=%b we=%b be=%h wd=%h addr=%h exp 1/1/f/11223344/00000404", cap_req, cap_we, cap_be, cap_wdata, cap_addr);
    end
    checks++;
    if ({we_o, stalls} !== {1'b0, 32'd3}) begin
      failures++; $display("FAIL sw_done got we=%b stalls=%0d exp 0/3", we_o, stalls);
    end
  endtask

  task automatic test_timeout;
    int reqs = 0, errs = 0, st = 0;
    logic s;
    mem_op_i = SW; mem_addr_i = 32'h500; mem_data_i = 32'h0BAD_F00D; we_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_req) reqs++;
      if (bus_err_o) errs++;
      s = stall_req;
      if (s) st++;
      @(posedge clk); #1;
      if (!s) mem_op_i = NOP;
    end
    checks++;
    if (reqs !== 4) begin failures++; $display("FAIL timeout_req_cycles got %0d exp 4", reqs); end
    checks++;
    if (errs !== 1) begin failures++; $display("FAIL timeout_err_pulses got %0d exp 1", errs); end
    checks++;
    if (st !== 4) begin failures++; $display("FAIL timeout_stall_cycles got %0d exp 4", st); end
    checks++;
    if ({we_o, bus_req} !== 2'b00) begin failures++; $display("FAIL timeout_final got we=%b req=%b exp 0/0", we_o, bus_req); end
  endtask

  task automatic test_reset_mid_wait;
    mem_op_i = LW; mem_addr_i = 32'h604; waddr_i = 5'd12; we_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus_req !== 1'b1) begin failures++; $display("FAIL midrst_pre_req got %b exp 1", bus_req); end
    @(posedge clk); #1;
    rst = 1'b0; mem_op_i = NOP; we_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({wdata_o, waddr_o, we_o, bus_req, bus_we, bus_be, bus_addr, bus_wdata, bus_err_o} !== '0) begin
      failures++; $display("FAIL midrst_outputs got req=%b be=%h addr=%h we=%b exp all 0", bus_req, bus_be, bus_addr, we_o);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({stall_req, bus_req} !== 2'b00) begin failures++; $display("FAIL midrst_after got stall=%b req=%b exp 0/0", stall_req, bus_req); end
    @(posedge clk); #1;
  endtask

  task automatic test_misalign;
`ifdef MEM_ALIGN_CHECK_EN
    mem_op_i = LW; mem_addr_i = 32'h102; waddr_i = 5'd6; we_i = 1'b1;
    @(negedge clk);
    checks++;
    if (stall_req !== 1'b0) begin failures++; $display("FAIL mis_stall got %b exp 0", stall_req); end
    @(posedge clk); #1;
    mem_op_i = NOP; we_i = 1'b0;
    checks++;
    if ({bus_req, bus_err_o, we_o} !== 3'b010) begin
      failures++; $display("FAIL mis_err got req=%b err=%b we=%b exp 0/1/0", bus_req, bus_err_o, we_o);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus_req, bus_err_o} !== 2'b00) begin failures++; $display("FAIL mis_pulse got req=%b err=%b exp 0/0", bus_req, bus_err_o); end
`else
    mem_txn(LW, 32'h102, 32'h0, 5'd6, 0, 32'h0000_55AA);
    checks++;
    if ({cap_req, cap_be, cap_addr} !== {1'b1, 4'hF, 32'h100}) begin
      failures++; $display("FAIL mis_bus got req=%b be=%h addr=%h exp 1/f/00000100", cap_req, cap_be, cap_addr);
    end
    checks++;
    if ({wdata_o, we_o, bus_err_o} !== {32'h55AA, 1'b1, 1'b0}) begin
      failures++; $display("FAIL mis_result got %h/%b err=%b exp 000055aa/1/0", wdata_o, we_o, bus_err_o);
    end
`endif
  endtask

  initial begin
    rst = 1'b0; mem_op_i = NOP; mem_addr_i = '0; mem_data_i = '0;
    wdata_i = '0; waddr_i = '0; we_i = 1'b0; bus_rdata = '0; bus_ack = 1'b0;
    test_reset;
    test_alu;
    test_lw;
    test_lb;
    test_back_to_back;
    test_timeout;
    test_reset_mid_wait;
    test_misalign;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the GeMIPS pipeline, directly downstream of the execute stage. It takes the ALU result and the memory request (op, address, store data) from execute, and runs LB/LW/SB/SW on a simple req/ack data bus. It stalls the upstream pipeline while the bus is busy and registers the final write-back result (waddr/we/wdata) toward the write-back stage.

## Interface

Parameters:
- BUS_TIMEOUT, 255: maximum cycles to wait for bus_ack before aborting; 8-bit counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- mem_op_i  in  8  memory op from execute (MEM_NOP/LB/LW/SB/SW)
- mem_addr_i  in  32  byte address from execute
- mem_data_i  in  32  store data from execute (SB: byte in [7:0])
- wdata_i  in  32  ALU result from execute
- waddr_i  in  5  destination register
- we_i  in  1  register write enable
- wdata_o  out  32  write-back data (registered)
- waddr_o  out  5  write-back register (registered)
- we_o  out  1  write-back enable (registered)
- stall_req  out  1  hold upstream stages (combinational)
- bus_req  out  1  bus request (registered)
- bus_we  out  1  1 = store
- bus_be  out  4  byte enables, little-endian
- bus_addr  out  32  word address, [1:0] forced 0
- bus_wdata  out  32  store data
- bus_rdata  in  32  load data, valid when bus_ack=1
- bus_ack  in  1  one-cycle completion strobe
- bus_err_o  out  1  one-cycle pulse on timeout (or misalign, see Configuration)

## Operation

- FSM states: IDLE, BUS.
- IDLE, mem_op_i == MEM_NOP: next edge wdata_o/waddr_o/we_o <= wdata_i/waddr_i/we_i; stall_req=0.
- IDLE, memory op: stall_req=1 combinationally. Next edge: latch op/address/data/waddr, drive bus_req=1, go to BUS, we_o <= 0 (bubble).
- BUS: bus_req held high with stable bus_* until bus_ack is sampled high. stall_req = !bus_ack.
- On the ack edge: bus_req <= 0, go to IDLE.
  - Loads: we_o <= 1, waddr_o <= latched waddr, wdata_o <= load data.
  - Stores: we_o <= 0, wdata_o <= 0.
- LW: bus_be=4'hF; wdata = bus_rdata.
- LB: bus_be = 4'b0001 << addr[1:0]; wdata = sign-extend(bus_rdata[8*addr[1:0] +: 8]).
- SB: bus_be as LB; bus_wdata = {4{data[7:0]}}.
- SW: bus_be=4'hF; bus_wdata = data.
- Timeout: the counter clears on entry to BUS and increments each BUS cycle without ack. When it reaches BUS_TIMEOUT: bus_req <= 0, bus_err_o pulses 1 cycle, we_o <= 0, return to IDLE, stall_req=0 in that cycle.
- Ack and timeout in the same cycle: ack wins.
- bus_ack while in IDLE: ignored.

## Timing

- Reset (rst=0 at edge): state IDLE, counter 0, all outputs 0 (wdata_o, waddr_o, we_o, bus_req, bus_we, bus_be, bus_addr, bus_wdata, bus_err_o). Takes effect mid-transaction; the in-flight access is dropped with no ack wait.
- Non-memory op: 1-cycle latency, no stall.
- Memory op with ack in the first BUS cycle:
  - cycle 0 (IDLE, stall=1)
  - cycle 1 (BUS, ack, stall=0)
  - result visible after edge ending cycle 1. Minimum 2 cycles; each ack-wait cycle adds 1.
- Upstream holds its outputs while stall_req=1 and advances on the first edge with stall_req=0.

## Configuration

- MEM_ALIGN_CHECK_EN defined:
  - LW/SW with mem_addr_i[1:0] != 0 is never issued to the bus and causes no stall.
  - Next edge: bus_err_o pulses 1, we_o <= 0.
- MEM_ALIGN_CHECK_EN undefined:
  - LW/SW with mem_addr_i[1:0] != 0 proceeds normally; address[1:0] is silently dropped and there is no error.
  - bus_err_o reports timeouts only.

## Structure

- Shared package/include holds:
  - MEM_NOP=8'h00, MEM_LB=8'h01, MEM_LW=8'h02, MEM_SB=8'h03, MEM_SW=8'h04.
  - FSM state encodings IDLE=1'b0, BUS=1'b1.
- One sub-module, mem_lane: combinational byte-lane steering. It produces bus_be/bus_wdata from op/addr/data, and the load result from op/addr/rdata. The FSM, counter and output registers stay in mem_access.

## Test plan

- ADD result 32'h0000_1234 to r5, mem_op=NOP -> next cycle wdata_o=32'h1234, waddr_o=5, we_o=1, stall_req never high.
- LW addr 32'h100, ack after 3 wait cycles, rdata 32'hDEADBEEF:
  - bus_be=4'hF, stall_req high 4 cycles
  - then wdata_o=32'hDEADBEEF, we_o=1.
- LB addr 32'h203, rdata 32'h80FF_0000, ack immediate:
  - bus_be=4'b1000, wdata_o=32'hFFFF_FF80.
- SB addr 32'h301, data 32'h0000_00A5:
  - bus_we=1, bus_be=4'b0010, bus_wdata=32'hA5A5A5A5, bus_addr=32'h300, we_o=0.
- SW with no ack, BUS_TIMEOUT=4:
  - bus_req drops after 4 BUS cycles, bus_err_o single pulse, stall_req released.
  - Separately, rst=0 mid-wait -> all outputs 0 next edge.
- With MEM_ALIGN_CHECK_EN, LW addr 32'h102 -> bus_req stays 0, bus_err_o pulse, we_o=0.
